// File: rtl/bp_fpga_host_pkg.sv
// Shared NBF definitions for the FPGA host path: default-width packet layout,
// opcode constants for downstream stages and a word-count helper.
package bp_fpga_host_pkg;

  localparam int nbf_opcode_width_gp = 8;
  localparam int nbf_addr_width_gp   = 64;
  localparam int nbf_data_width_gp   = 64;

  // Field order puts the opcode in the LSBs, matching the host word order.
  typedef struct packed {
    logic [nbf_data_width_gp-1:0]   data;
    logic [nbf_addr_width_gp-1:0]   addr;
    logic [nbf_opcode_width_gp-1:0] opcode;
  } bp_fpga_host_nbf_s;

  localparam logic [7:0] nbf_op_write_4_gp = 8'h02;
  localparam logic [7:0] nbf_op_write_8_gp = 8'h03;
  localparam logic [7:0] nbf_op_read_4_gp  = 8'h12;
  localparam logic [7:0] nbf_op_read_8_gp  = 8'h13;
  localparam logic [7:0] nbf_op_fence_gp   = 8'hFE;
  localparam logic [7:0] nbf_op_finish_gp  = 8'hFF;

  function automatic int nbf_words(input int nbf_width, input int word_width);
    return (nbf_width + word_width - 1) / word_width;
  endfunction

endpackage

// File: rtl/blackparrot_fpga_host_nbf_sipo.sv
// Host-word to NBF-packet deserializer: gathers words LSB-first into one packet,
// presents it on a valid/ready_and port and tracks packet count and pad errors.
module blackparrot_fpga_host_nbf_sipo
  import bp_fpga_host_pkg::*;
#(
  parameter int fifo_data_width_p  = 32,
  parameter int nbf_opcode_width_p = 8,
  parameter int nbf_addr_width_p   = 64,
  parameter int nbf_data_width_p   = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          word_v_i,
  input  logic [fifo_data_width_p-1:0]  word_data_i,
  output logic                          word_ready_and_o,
  output logic                          nbf_v_o,
  output logic [nbf_opcode_width_p-1:0] nbf_opcode_o,
  output logic [nbf_addr_width_p-1:0]   nbf_addr_o,
  output logic [nbf_data_width_p-1:0]   nbf_data_o,
  input  logic                          nbf_ready_and_i,
  output logic [31:0]                   pkt_count_o,
  output logic                          pad_err_o
);

  localparam int nbf_width_lp = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p;
  localparam int words_lp     = nbf_words(nbf_width_lp, fifo_data_width_p);
  localparam int pad_lp       = words_lp * fifo_data_width_p - nbf_width_lp;
  localparam int cnt_width_lp = (words_lp > 1) ? $clog2(words_lp) : 1;

  localparam logic [0:0] state_collect = 1'b0;
  localparam logic [0:0] state_send    = 1'b1;

  typedef struct packed {
    logic [nbf_data_width_p-1:0]   data;
    logic [nbf_addr_width_p-1:0]   addr;
    logic [nbf_opcode_width_p-1:0] opcode;
  } nbf_s;

  logic [0:0]              state_reg, state_next;
  logic [cnt_width_lp-1:0] word_cnt_reg, word_cnt_next;
  logic [31:0]             pkt_count_reg;
  logic                    pad_err_reg;
  logic                    word_hs, nbf_hs, last_word, pad_nz;
  logic [nbf_width_lp-1:0] buffer;
  nbf_s                    nbf_cast;

  assign word_hs   = word_v_i & (state_reg == state_collect);
  assign nbf_hs    = nbf_ready_and_i & (state_reg == state_send);
  assign last_word = (word_cnt_reg == cnt_width_lp'(words_lp - 1));

  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    case (state_reg)
      state_collect: begin
        if (word_hs) begin
          if (last_word) begin
            word_cnt_next = '0;
            state_next    = state_send;
          end else begin
            word_cnt_next = word_cnt_reg + cnt_width_lp'(1);
          end
        end
      end
      default: begin
        if (nbf_hs) state_next = state_collect;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg     <= state_collect;
      word_cnt_reg  <= '0;
      pkt_count_reg <= '0;
      pad_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      word_cnt_reg <= word_cnt_next;
      if (nbf_hs) pkt_count_reg <= pkt_count_reg + 32'd1;
      if (word_hs && last_word && pad_nz) pad_err_reg <= 1'b1;
    end
  end

  // One register per word slot; the top slot drops the pad bits, which are only
  // inspected on the fly for the error flag.
  for (genvar gi = 0; gi < words_lp; gi++) begin : g_slot
    localparam int slot_w = (gi == words_lp - 1) ? fifo_data_width_p - pad_lp : fifo_data_width_p;
    logic [slot_w-1:0] slot_reg;

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        slot_reg <= '0;
      end else if (word_hs && (word_cnt_reg == cnt_width_lp'(gi))) begin
        slot_reg <= word_data_i[slot_w-1:0];
      end
    end

    assign buffer[gi*fifo_data_width_p +: slot_w] = slot_reg;
  end

  if (pad_lp > 0) begin : g_pad
    assign pad_nz = |word_data_i[fifo_data_width_p-1 -: pad_lp];
  end else begin : g_no_pad
    assign pad_nz = 1'b0;
  end

  assign nbf_cast         = nbf_s'(buffer);
  assign word_ready_and_o = (state_reg == state_collect);
  assign nbf_v_o          = (state_reg == state_send);
  assign nbf_opcode_o     = nbf_cast.opcode;
  assign nbf_addr_o       = nbf_cast.addr;
  assign nbf_data_o       = nbf_cast.data;
  assign pkt_count_o      = pkt_count_reg;
  assign pad_err_o        = pad_err_reg;

`ifndef SYNTHESIS
  logic stall_reg;
  nbf_s held_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_reg <= 1'b0;
      held_reg  <= '0;
    end else begin
      assert (fifo_data_width_p == 32) else $error("host word width must be 32");
      assert (nbf_width_lp <= words_lp * 32) else $error("packet wider than word buffer");
      if (stall_reg) assert (nbf_cast == held_reg) else $error("packet changed while stalled");
      stall_reg <= nbf_v_o & ~nbf_ready_and_i;
      held_reg  <= nbf_cast;
    end
  end
`endif

endmodule

// File: tb/tb_blackparrot_fpga_host_nbf_sipo.sv
// Bench: directed cases plus 1000 random packets against a word-queue packet model.
module tb_blackparrot_fpga_host_nbf_sipo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        word_v, word_ready, nbf_v, nbf_ready, pad_err;
  logic [31:0] word_data, pkt_count;
  logic [7:0]  nbf_op;
  logic [63:0] nbf_addr, nbf_data;

  logic        s_word_v, s_word_ready, s_nbf_v, s_nbf_ready, s_pad_err;
  logic [31:0] s_word_data, s_pkt_count, s_nbf_addr, s_nbf_data;
  logic [7:0]  s_nbf_op;

  blackparrot_fpga_host_nbf_sipo dut (
    .clk_i(clk), .reset_i(reset),
    .word_v_i(word_v), .word_data_i(word_data), .word_ready_and_o(word_ready),
    .nbf_v_o(nbf_v), .nbf_opcode_o(nbf_op), .nbf_addr_o(nbf_addr), .nbf_data_o(nbf_data),
    .nbf_ready_and_i(nbf_ready), .pkt_count_o(pkt_count), .pad_err_o(pad_err)
  );

  blackparrot_fpga_host_nbf_sipo #(
    .fifo_data_width_p(32), .nbf_opcode_width_p(8), .nbf_addr_width_p(32), .nbf_data_width_p(32)
  ) dut_s (
    .clk_i(clk), .reset_i(reset),
    .word_v_i(s_word_v), .word_data_i(s_word_data), .word_ready_and_o(s_word_ready),
    .nbf_v_o(s_nbf_v), .nbf_opcode_o(s_nbf_op), .nbf_addr_o(s_nbf_addr), .nbf_data_o(s_nbf_data),
    .nbf_ready_and_i(s_nbf_ready), .pkt_count_o(s_pkt_count), .pad_err_o(s_pad_err)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  op;
    logic [63:0] addr;
    logic [63:0] data;
  } pkt_t;

  pkt_t        exp_q[$];
  logic [31:0] words_q[$];
  bit          pad_exp;
  int unsigned cnt_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Five 32-bit words concatenated LSB-first: opcode [7:0], addr [71:8], data [135:72], pad above.
  task automatic model_word(input logic [31:0] w);
    logic [159:0] v;
    pkt_t p;
    words_q.push_back(w);
    if (words_q.size() == 5) begin
      v = '0;
      for (int k = 0; k < 5; k++) v = v | (160'(words_q[k]) << (32 * k));
      p.op   = v[7:0];
      p.addr = v[71:8];
      p.data = v[135:72];
      if (v[159:136] != 24'd0) pad_exp = 1'b1;
      exp_q.push_back(p);
      words_q.delete();
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    words_q.delete();
    pad_exp = 1'b0;
    cnt_exp = 0;
  endtask

  // Check the current outputs, drive one cycle of inputs, then advance the model.
  task automatic step(input bit v, input logic [31:0] d, input bit r);
    bit word_hs, nbf_hs;
    word_v    = v;
    word_data = d;
    nbf_ready = r;
    check("nbf_v", 64'(nbf_v), 64'(exp_q.size() != 0));
    check("word_ready", 64'(word_ready), 64'(exp_q.size() == 0));
    check("pkt_count", 64'(pkt_count), 64'(cnt_exp));
    check("pad_err", 64'(pad_err), 64'(pad_exp));
    if (exp_q.size() != 0) begin
      check("opcode", 64'(nbf_op), 64'(exp_q[0].op));
      check("addr", nbf_addr, exp_q[0].addr);
      check("data", nbf_data, exp_q[0].data);
    end
    word_hs = v && (exp_q.size() == 0);
    nbf_hs  = r && (exp_q.size() != 0);
    @(posedge clk); #1;
    if (nbf_hs) begin
      void'(exp_q.pop_front());
      cnt_exp++;
    end
    if (word_hs) model_word(d);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, 32'd0, 1'b1);
    check("drain_done", 64'(nbf_v), 64'd0);
  endtask

  function automatic logic [31:0] clean_last(input logic [31:0] w);
    return w & 32'h0000_00FF;
  endfunction

  initial begin
    logic [31:0] w[5];
    logic [31:0] sw[3];
    int cyc;
    bit v, r;
    logic [31:0] d;

    reset = 1'b1;
    word_v = 1'b0; word_data = '0; nbf_ready = 1'b0;
    s_word_v = 1'b0; s_word_data = '0; s_nbf_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    check("rst_word_ready", 64'(word_ready), 64'd1);
    check("rst_nbf_v", 64'(nbf_v), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    check("rst_pad_err", 64'(pad_err), 64'd0);
    check("rst_s_word_ready", 64'(s_word_ready), 64'd1);

    // 8/32/32: words chosen so the layout yields opcode 02, addr 40, data DEADBEEF.
    sw[0] = 32'h0000_4002; sw[1] = 32'hADBE_EF00; sw[2] = 32'h0000_00DE;
    for (int k = 0; k < 3; k++) begin
      s_word_v = 1'b1; s_word_data = sw[k];
      @(posedge clk); #1;
    end
    s_word_v = 1'b0;
    check("s_nbf_v", 64'(s_nbf_v), 64'd1);
    check("s_word_ready_busy", 64'(s_word_ready), 64'd0);
    check("s_opcode", 64'(s_nbf_op), 64'h02);
    check("s_addr", 64'(s_nbf_addr), 64'h0000_0040);
    check("s_data", 64'(s_nbf_data), 64'hDEAD_BEEF);
    check("s_pad_err", 64'(s_pad_err), 64'd0);
    @(posedge clk); #1;
    check("s_pkt_count", 64'(s_pkt_count), 64'd1);
    check("s_nbf_v_after", 64'(s_nbf_v), 64'd0);

    // Directed packet with known field values.
    w[0] = 32'h3344_5503; w[1] = 32'h0011_2200; w[2] = 32'hDDEE_FF00;
    w[3] = 32'hAABB_CC00; w[4] = 32'h0000_0000;
    for (int k = 0; k < 5; k++) step(1'b1, w[k], 1'b1);
    check("d1_nbf_v", 64'(nbf_v), 64'd1);
    check("d1_opcode", 64'(nbf_op), 64'h03);
    check("d1_addr", nbf_addr, 64'h0000_1122_0033_4455);
    check("d1_data", nbf_data, 64'h00AA_BBCC_00DD_EEFF);
    step(1'b0, 32'd0, 1'b1);
    check("d1_pkt_count", 64'(pkt_count), 64'd1);
    check("d1_pad_err", 64'(pad_err), 64'd0);

    // Backpressure: packet held for 10 cycles while words keep arriving.
    for (int k = 0; k < 5; k++) step(1'b1, (k == 4) ? clean_last($urandom) : $urandom, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'hBAD0_0000 | i, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b1, (k == 5) ? clean_last($urandom) : $urandom, 1'b1);
    drain();
    check("bp_pkt_count", 64'(pkt_count), 64'd3);

    // Nonzero pad bit, then a clean packet: flag stays set.
    for (int k = 0; k < 5; k++) step(1'b1, (k == 4) ? 32'h0000_0100 : $urandom, 1'b1);
    drain();
    check("pad_set", 64'(pad_err), 64'd1);
    for (int k = 0; k < 5; k++) step(1'b1, (k == 4) ? clean_last($urandom) : $urandom, 1'b1);
    drain();
    check("pad_sticky", 64'(pad_err), 64'd1);

    // Reset after three words, with word_v held high through reset.
    for (int k = 0; k < 3; k++) step(1'b1, 32'hFFFF_FFFF, 1'b1);
    word_v = 1'b1; word_data = 32'hFFFF_FFFF; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) step(1'b1, (k == 4) ? clean_last($urandom) : $urandom, 1'b1);
    drain();
    check("rst_mid_pkt_count", 64'(pkt_count), 64'd1);
    check("rst_mid_pad_err", 64'(pad_err), 64'd0);

    // Random traffic from a clean reset.
    reset = 1'b1; word_v = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    cyc = 0;
    while (cnt_exp < 1000 && cyc < 40000) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      d = $urandom;
      if (words_q.size() == 4 && $urandom_range(0, 49) != 0) d = clean_last(d);
      step(v, d, r);
      cyc++;
    end
    check("rand_pkt_count", 64'(pkt_count), 64'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
